// File: rtl/mult_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mult_pkg : state encoding and shared width for the shift-add multiplier
// Revision : 1.0
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    ITER  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // One extra bit so the iteration counter never wraps within an operation.
  function automatic int cnt_bits(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mult_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_mult_if : start/busy/valid request bus of the sequential multiplier
// Revision    : 1.0
// ---------------------------------------------------------------------------
interface seq_mult_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) ();

  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy;
  logic               valid;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, a_in, b_in,
    input  busy, valid, product
  );

  modport slave (
    input  start, a_in, b_in,
    output busy, valid, product
  );

endinterface
`default_nettype wire

// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_mult_ctrl : controller FSM and iteration terminal compare
// Revision      : 1.0
// ---------------------------------------------------------------------------
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = cnt_bits(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             zero_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             ld_o,
  output logic             add_en_o,
  output logic             shift_en_o,
  output logic             ld_prod_o,
  output logic             busy_o,
  output logic             valid_o
);

  state_t state_q;
  state_t state_d;
  logic   w_last;

  assign w_last = (cnt_i == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ld_o       = 1'b0;
    add_en_o   = 1'b0;
    shift_en_o = 1'b0;
    ld_prod_o  = 1'b0;
    busy_o     = 1'b0;
    valid_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = LOAD;
      end
      LOAD: begin
        busy_o  = 1'b1;
        ld_o    = 1'b1;
        state_d = CHECK;
      end
      CHECK: begin
        busy_o = 1'b1;
        // Fast path: ld_prod without shift_en makes the datapath load zero.
        if (zero_i) begin
          ld_prod_o = 1'b1;
          state_d   = DONE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        busy_o     = 1'b1;
        add_en_o   = 1'b1;
        shift_en_o = 1'b1;
        if (w_last) begin
          ld_prod_o = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        valid_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seq_mult.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_mult : unsigned shift-add multiplier, one iteration per clock
// Revision : 1.0
// ---------------------------------------------------------------------------
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  seq_mult_if.slave  bus
);

  localparam int CNT_W = cnt_bits(WIDTH);

  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH:0]     hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic               w_ld, w_add_en, w_shift_en, w_ld_prod, w_busy, w_valid;
  logic               w_zero;
  logic [WIDTH:0]     w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_shift;

  seq_mult_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .start_i    (bus.start),
    .zero_i     (w_zero),
    .cnt_i      (cnt_q),
    .ld_o       (w_ld),
    .add_en_o   (w_add_en),
    .shift_en_o (w_shift_en),
    .ld_prod_o  (w_ld_prod),
    .busy_o     (w_busy),
    .valid_o    (w_valid)
  );

  assign w_zero   = (a_q == '0) || (lo_q == '0);
  assign w_addend = (w_add_en && lo_q[0]) ? {1'b0, a_q} : '0;
  // hi keeps the carry bit, so the add cannot overflow before the shift.
  assign w_sum    = hi_q + w_addend;
  assign w_shift  = {w_sum, lo_q} >> 1;

  always_comb begin
    a_d       = a_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    if (w_ld) begin
      a_d   = bus.a_in;
      lo_d  = bus.b_in;
      hi_d  = '0;
      cnt_d = '0;
    end else if (w_shift_en) begin
      hi_d  = w_shift[2*WIDTH:WIDTH];
      lo_d  = w_shift[WIDTH-1:0];
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (w_ld_prod) begin
      product_d = w_shift_en ? w_shift[2*WIDTH-1:0] : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      a_q       <= a_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = w_busy;
  assign bus.valid   = w_valid;
  assign bus.product = product_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_mult : directed and random checks of seq_mult against a*b
// Revision    : 1.0
// ---------------------------------------------------------------------------
module tb_seq_mult;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  seq_mult_if #(.WIDTH(W)) bus ();

  seq_mult #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkp(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One request; the reference is plain multiplication and the documented latency.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep_start);
    int             lat;
    logic [2*W-1:0] exp_p;
    exp_p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    lat   = (a == '0 || b == '0) ? 2 : W + 2;
    bus.start = 1'b1;
    bus.a_in  = a;
    bus.b_in  = b;
    @(posedge clk); #1;
    if (!keep_start) bus.start = 1'b0;
    chk1("busy_e0", bus.busy, 1'b1);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        bus.a_in = W'($urandom);
        bus.b_in = W'($urandom);
      end
      chk1("busy", bus.busy, k < lat);
      chk1("valid", bus.valid, k == lat);
    end
    chkp("product", bus.product, exp_p);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk1("valid_once", bus.valid, 1'b0);
    chk1("idle_busy", bus.busy, 1'b0);
    chkp("product_hold", bus.product, exp_p);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bus.start = 1'b0;
    bus.a_in  = '0;
    bus.b_in  = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_valid", bus.valid, 1'b0);
    chkp("rst_product", bus.product, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    op(8'd13, 8'd11, 1'b0);
    op(8'd255, 8'd255, 1'b0);
    op(8'd0, 8'd200, 1'b0);
    op(8'd77, 8'd0, 1'b0);
    op(8'd6, 8'd7, 1'b1);

    // Abort in the middle of the iterations.
    bus.start = 1'b1;
    bus.a_in  = 8'd200;
    bus.b_in  = 8'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk1("abort_busy", bus.busy, 1'b0);
    chk1("abort_valid", bus.valid, 1'b0);
    chkp("abort_product", bus.product, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      chk1("abort_no_valid", bus.valid, 1'b0);
    end
    op(8'd9, 8'd9, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom);
      op(ra, rb, n[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
